// File: rtl/collision_rom_arbiter.sv
// collision_rom_arbiter
//   Shares one collision ROM among five agents (pacman plus four ghosts).
//   A winning request is latched. The ROM row for {map_num, y} is then read,
//   and the agent gets a 4-bit move nibble taken from the row at 4*x.
//
//   Arbitration mode:
//     COLLISION_ARB_ROUND_ROBIN_EN defined   -> round-robin. The search starts
//                                               at the agent after the last winner.
//     COLLISION_ARB_ROUND_ROBIN_EN undefined -> fixed priority. Agent 0 is the
//                                               highest priority.
//
//   Ports
//     clk_100mhz   in   1  system clock, rising edge
//     rst          in   1  asynchronous active-high reset
//     map_num      in   2  current map select
//     req          in   5  level request per agent, held until ack
//     req_x        in  30  packed x, 6 bits per agent (bit 5 unused)
//     req_y        in  25  packed y, 5 bits per agent
//     rom_dout     in  76  collision ROM row, ROM_LATENCY cycles after rom_addr
//     ack          out  5  one-hot completion pulse, high only in RESP
//     valid_moves  out  4  move nibble, valid in the ack cycle, held afterwards
//     rom_addr     out  7  registered ROM address {map_num, y}
//     busy         out  1  high whenever the FSM is not IDLE
//     dbg_state    out  2  current FSM state, for observation
//
//   Handshake: an agent holds req high until it sees its ack bit. It must
//   drop req in the cycle after ack. If req is still high once the FSM is
//   back in IDLE, it counts as a new request.
module collision_rom_arbiter #(
    parameter int ROM_LATENCY = 1   // legal 1..3
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic [1:0]  map_num,
    input  logic [4:0]  req,
    input  logic [29:0] req_x,
    input  logic [24:0] req_y,
    input  logic [75:0] rom_dout,
    output logic [4:0]  ack,
    output logic [3:0]  valid_moves,
    output logic [6:0]  rom_addr,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(ROM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [2:0] win_q, win_d;
    logic [4:0] x_q, x_d;
    logic [6:0] addr_lat_q, addr_lat_d;
    logic [6:0] rom_addr_q, rom_addr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] vm_q, vm_d;

    logic [2:0] grant_idx;
    logic [4:0] x_arr [5];
    logic [4:0] y_arr [5];
    logic [3:0] row_nib;
    logic [3:0] nibble;
    logic       x_bit5_unused;

    // Unpack per-agent coordinates. The top x bit is never used.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            x_arr[i] = req_x[6*i +: 5];
            y_arr[i] = req_y[5*i +: 5];
        end
    end
    assign x_bit5_unused = ^{req_x[29], req_x[23], req_x[17], req_x[11], req_x[5]};

`ifdef COLLISION_ARB_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;

    // Take the first requester found when searching upward from ptr_q,
    // wrapping from 4 back to 0.
    always_comb begin
        logic [3:0] sum;
        logic       found;
        grant_idx = 3'd0;
        found     = 1'b0;
        sum       = 4'd0;
        for (int k = 0; k < 5; k++) begin
            sum = {1'b0, ptr_q} + 4'(k);
            if (sum >= 4'd5) sum = sum - 4'd5;
            if (!found && req[sum[2:0]]) begin
                grant_idx = sum[2:0];
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) ptr_q <= 3'd0;
        else     ptr_q <= ptr_d;
    end
`else
    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        grant_idx = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (req[k]) grant_idx = 3'(k);
        end
    end
`endif

    // Move nibble. The row is shifted down to the base bit 4*x.
    // A base past bit 75 (x > 18) gives no moves.
    assign row_nib = 4'(rom_dout >> {x_q, 2'b00});
    assign nibble  = (x_q > 5'd18) ? 4'b0000
                                   : {row_nib[3], row_nib[2], row_nib[0], row_nib[1]};

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        x_d        = x_q;
        addr_lat_d = addr_lat_q;
        rom_addr_d = rom_addr_q;
        cnt_d      = cnt_q;
        vm_d       = vm_q;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // Coordinates and map are frozen here for the whole transaction.
                    win_d      = grant_idx;
                    x_d        = x_arr[grant_idx];
                    addr_lat_d = {map_num, y_arr[grant_idx]};
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
                    ptr_d      = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
`endif
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                rom_addr_d = addr_lat_q;
                cnt_d      = CNT_LOAD;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_RESP: begin
                vm_d    = nibble;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            win_q      <= 3'd0;
            x_q        <= 5'd0;
            addr_lat_q <= 7'd0;
            rom_addr_q <= 7'd0;
            cnt_q      <= 2'd0;
            vm_q       <= 4'd0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            x_q        <= x_d;
            addr_lat_q <= addr_lat_d;
            rom_addr_q <= rom_addr_d;
            cnt_q      <= cnt_d;
            vm_q       <= vm_d;
        end
    end

    // In RESP, ack and valid_moves are decoded from registered state and the
    // ROM data that arrives in that cycle. After RESP, the nibble held in vm_q
    // keeps driving valid_moves.
    assign ack         = (state_q == S_RESP) ? (5'b00001 << win_q) : 5'b00000;
    assign valid_moves = (state_q == S_RESP) ? nibble : vm_q;
    assign rom_addr    = rom_addr_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_collision_rom_arbiter.sv
// Directed bench for collision_rom_arbiter.
// Instance a uses ROM_LATENCY=1 and instance b uses ROM_LATENCY=3.
// Both share the clock and the reset.
module tb_collision_rom_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a, latency 1
  logic [1:0]  a_map = '0;
  logic [4:0]  a_req = '0;
  logic [29:0] a_x = '0;
  logic [24:0] a_y = '0;
  logic [75:0] a_rom_dout = '0;
  logic [4:0]  a_ack;
  logic [3:0]  a_vm;
  logic [6:0]  a_rom_addr;
  logic        a_busy;
  logic [1:0]  a_dbg;

  // instance b, latency 3
  logic [1:0]  b_map = '0;
  logic [4:0]  b_req = '0;
  logic [29:0] b_x = '0;
  logic [24:0] b_y = '0;
  logic [75:0] b_rom_dout = '0;
  logic [75:0] b_p1 = '0;
  logic [75:0] b_p2 = '0;
  logic [4:0]  b_ack;
  logic [3:0]  b_vm;
  logic [6:0]  b_rom_addr;
  logic        b_busy;
  logic [1:0]  b_dbg;

  logic [75:0] rom_mem [128];

  int errors = 0;
  int checks = 0;

  collision_rom_arbiter #(.ROM_LATENCY(1)) dut_a (
    .clk_100mhz(clk), .rst(rst), .map_num(a_map), .req(a_req),
    .req_x(a_x), .req_y(a_y), .rom_dout(a_rom_dout), .ack(a_ack),
    .valid_moves(a_vm), .rom_addr(a_rom_addr), .busy(a_busy), .dbg_state(a_dbg)
  );

  collision_rom_arbiter #(.ROM_LATENCY(3)) dut_b (
    .clk_100mhz(clk), .rst(rst), .map_num(b_map), .req(b_req),
    .req_x(b_x), .req_y(b_y), .rom_dout(b_rom_dout), .ack(b_ack),
    .valid_moves(b_vm), .rom_addr(b_rom_addr), .busy(b_busy), .dbg_state(b_dbg)
  );

  // ROM models with 1-cycle and 3-cycle read pipelines.
  always @(posedge clk) begin
    a_rom_dout <= rom_mem[a_rom_addr];
    b_p1       <= rom_mem[b_rom_addr];
    b_p2       <= b_p1;
    b_rom_dout <= b_p2;
  end

  // Drive one request on instance a. Sampling happens on negedges.
  // lat is the number of negedges from the first sampling edge until ack is seen.
  task automatic do_txn_a(input int agent, input logic [1:0] map, input logic [4:0] y,
                          input logic [5:0] x, output int lat, output logic [4:0] ack_v,
                          output logic [3:0] vm_v, output logic [6:0] addr_v);
    @(negedge clk);
    a_map = map;
    a_x = '0;
    a_y = '0;
    a_x[6*agent +: 6] = x;
    a_y[5*agent +: 5] = y;
    a_req = '0;
    a_req[agent] = 1'b1;
    lat = 0;
    ack_v = '0;
    while (ack_v == 5'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
      ack_v = a_ack;
    end
    vm_v = a_vm;
    addr_v = a_rom_addr;
    a_req = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_ack !== 5'b0) begin errors++; $display("FAIL reset_ack_a: got %b expected 00000", a_ack); end
    checks++; if (a_vm !== 4'b0) begin errors++; $display("FAIL reset_vm_a: got %b expected 0000", a_vm); end
    checks++; if (a_rom_addr !== 7'b0) begin errors++; $display("FAIL reset_addr_a: got %b expected 0000000", a_rom_addr); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", a_busy); end
    checks++; if (b_dbg !== 2'd0) begin errors++; $display("FAIL reset_state_b: got %0d expected 0", b_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    // agent 0, map 2, y 7, x 3 -> addr 1000111, base 12
    // row bits 15 and 13 set -> {r15,r14,r12,r13} = 1001
    rom_mem[7'b1000111] = 76'hA000;
    @(negedge clk);
    a_map = 2'd2; a_x = '0; a_y = '0;
    a_x[5:0] = 6'd3; a_y[4:0] = 5'd7;
    a_req = 5'b00001;
    @(negedge clk); // after the grant edge
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", a_busy); end
    checks++; if (a_ack !== 5'b0) begin errors++; $display("FAIL single_early_ack1: got %b expected 00000", a_ack); end
    @(negedge clk); // after READ
    checks++; if (a_rom_addr !== 7'b1000111) begin errors++; $display("FAIL single_addr: got %b expected 1000111", a_rom_addr); end
    checks++; if (a_ack !== 5'b0) begin errors++; $display("FAIL single_early_ack2: got %b expected 00000", a_ack); end
    @(negedge clk); // RESP: ack is sampled at the third edge
    checks++; if (a_ack !== 5'b00001) begin errors++; $display("FAIL single_ack: got %b expected 00001", a_ack); end
    checks++; if (a_vm !== 4'b1001) begin errors++; $display("FAIL single_vm: got %b expected 1001", a_vm); end
    a_req = '0;
    @(negedge clk);
    checks++; if (a_ack !== 5'b0) begin errors++; $display("FAIL single_ack_drop: got %b expected 00000", a_ack); end
    checks++; if (a_vm !== 4'b1001) begin errors++; $display("FAIL single_vm_hold: got %b expected 1001", a_vm); end
  endtask

  task automatic test_nibble;
    int          ag   [4] = '{1, 4, 0, 3};
    logic [1:0]  mp   [4] = '{2'd0, 2'd3, 2'd1, 2'd2};
    logic [4:0]  yy   [4] = '{5'd3, 5'd31, 5'd2, 5'd10};
    logic [5:0]  xx   [4] = '{6'd0, 6'd18, 6'd19, 6'b100011};
    logic [75:0] row  [4] = '{76'h2, 76'h5 << 72, {76{1'b1}}, 76'hA000};
    logic [3:0]  exp_vm [4] = '{4'b0001, 4'b0110, 4'b0000, 4'b1001};
    int lat;
    logic [4:0] ack_v;
    logic [3:0] vm_v;
    logic [6:0] addr_v;
    for (int i = 0; i < 4; i++) rom_mem[{mp[i], yy[i]}] = row[i];
    for (int i = 0; i < 4; i++) begin
      do_txn_a(ag[i], mp[i], yy[i], xx[i], lat, ack_v, vm_v, addr_v);
      checks++; if (lat !== 3) begin errors++; $display("FAIL nib%0d_latency: got %0d expected 3", i, lat); end
      checks++; if (ack_v !== (5'b00001 << ag[i])) begin errors++; $display("FAIL nib%0d_ack: got %b expected agent %0d", i, ack_v, ag[i]); end
      checks++; if (vm_v !== exp_vm[i]) begin errors++; $display("FAIL nib%0d_vm: got %b expected %b", i, vm_v, exp_vm[i]); end
      checks++; if (addr_v !== {mp[i], yy[i]}) begin errors++; $display("FAIL nib%0d_addr: got %b expected %b", i, addr_v, {mp[i], yy[i]}); end
    end
  endtask

  task automatic test_sample_at_grant;
    int lat;
    // original row: x 5 -> base 20, bit 22 set -> 0100; the moved-to row is all ones
    rom_mem[7'b0110100] = 76'h1 << 22;
    rom_mem[7'b1101001] = {76{1'b1}};
    @(negedge clk);
    a_map = 2'd1; a_x = '0; a_y = '0;
    a_x[17:12] = 6'd5; a_y[14:10] = 5'd20;
    a_req = 5'b00100;
    @(negedge clk); // granted; now change the inputs
    a_map = 2'd3; a_y[14:10] = 5'd9; a_x[17:12] = 6'd0;
    @(negedge clk);
    checks++; if (a_rom_addr !== 7'b0110100) begin errors++; $display("FAIL sag_addr: got %b expected 0110100", a_rom_addr); end
    lat = 2;
    while (a_ack == 5'b0 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (a_ack !== 5'b00100) begin errors++; $display("FAIL sag_ack: got %b expected 00100", a_ack); end
    checks++; if (a_vm !== 4'b0100) begin errors++; $display("FAIL sag_vm: got %b expected 0100", a_vm); end
    a_req = '0;
    repeat (3) @(negedge clk);
    checks++; if (a_rom_addr !== 7'b0110100) begin errors++; $display("FAIL sag_addr_hold: got %b expected 0110100", a_rom_addr); end
    checks++; if (a_ack !== 5'b0) begin errors++; $display("FAIL sag_ack_idle: got %b expected 00000", a_ack); end
  endtask

  task automatic test_all_requests;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
    int exp_ord [6] = '{0, 1, 2, 3, 4, 0};
`else
    int exp_ord [6] = '{0, 0, 0, 0, 0, 0};
`endif
    int n = 0;
    int cyc = 0;
    int last = 0;
    // reset first so that arbitration starts from pointer 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    a_map = '0; a_x = '0; a_y = '0;
    a_req = 5'b11111;
    while (n < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_ack != 5'b0) begin
        checks++; if (!$onehot(a_ack)) begin errors++; $display("FAIL all_onehot%0d: got %b expected one bit", n, a_ack); end
        checks++; if (a_ack !== (5'b00001 << exp_ord[n])) begin errors++; $display("FAIL all_order%0d: got %b expected agent %0d", n, a_ack, exp_ord[n]); end
        if (n > 0) begin
          checks++; if (cyc - last != 4) begin errors++; $display("FAIL all_spacing%0d: got %0d expected 4", n, cyc - last); end
        end
        last = cyc;
        n++;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL all_count: got %0d expected 6 acks", n); end
    a_req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_in_wait;
    int lat;
    // agent 3, map 2, y 5, x 1 -> addr 1000101, base 4, row 0x90 -> 1010
    rom_mem[7'b1000101] = 76'h90;
    @(negedge clk);
    b_map = 2'd2; b_x = '0; b_y = '0;
    b_x[23:18] = 6'd1; b_y[19:15] = 5'd5;
    b_req = 5'b01000;
    lat = 0;
    while (b_ack == 5'b0 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL lat3_latency: got %0d expected 5", lat); end
    checks++; if (b_vm !== 4'b1010) begin errors++; $display("FAIL lat3_vm: got %b expected 1010", b_vm); end
    b_req = '0;
    // second request, reset while in WAIT
    @(negedge clk);
    b_req = 5'b01000;
    repeat (3) @(negedge clk);
    checks++; if (b_dbg !== 2'd2) begin errors++; $display("FAIL rw_in_wait: got %0d expected 2", b_dbg); end
    rst = 1'b1;
    #1;
    checks++; if (b_ack !== 5'b0) begin errors++; $display("FAIL rw_ack: got %b expected 00000", b_ack); end
    checks++; if (b_vm !== 4'b0) begin errors++; $display("FAIL rw_vm: got %b expected 0000", b_vm); end
    checks++; if (b_rom_addr !== 7'b0) begin errors++; $display("FAIL rw_addr: got %b expected 0000000", b_rom_addr); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b expected 0", b_busy); end
    @(negedge clk);
    checks++; if (b_ack !== 5'b0) begin errors++; $display("FAIL rw_ack_hold: got %b expected 00000", b_ack); end
    rst = 1'b0;
    lat = 0;
    while (b_ack == 5'b0 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rw_relatency: got %0d expected 5", lat); end
    checks++; if (b_ack !== 5'b01000) begin errors++; $display("FAIL rw_reack: got %b expected 01000", b_ack); end
    checks++; if (b_vm !== 4'b1010) begin errors++; $display("FAIL rw_revm: got %b expected 1010", b_vm); end
    b_req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = '0;
    test_reset();
    test_single();
    test_nibble();
    test_sample_at_grant();
    test_all_requests();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/collision_rom_arbiter.md
COLLISION_ROM_ARBITER -- requirements
Module: collision_rom_arbiter

Interface
REQ-001 Parameter: ROM_LATENCY, default 1, cycles from rom_addr change to valid rom_dout; legal 1..3.
REQ-002 Clock and reset: one clock, clk_100mhz; reset is rst, asynchronous, active-high.
REQ-003 clk_100mhz  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 map_num  in  2  current map select.
REQ-006 req  in  5  request per agent: bit0 pacman, bits1-4 ghost1-4; level, held until ack.
REQ-007 req_x  in  30  packed x, 6 bits per agent, agent i at [6i+5:6i].
REQ-008 req_y  in  25  packed y, 5 bits per agent, agent i at [5i+4:5i].
REQ-009 ack  out  5  one-hot, one-cycle pulse marking completion for that agent.
REQ-010 valid_moves  out  4  move nibble; valid only in the ack cycle.
REQ-011 rom_addr  out  7  collision ROM address {map_num, y}, registered.
REQ-012 rom_dout  in  76  collision ROM row data.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, READ, WAIT, RESP.
REQ-015 IDLE: if any req bit is high, select one winner, latch its index, x[4:0], and {map_num, y}, then go to READ; otherwise stay.
REQ-016 READ: drive the latched address on rom_addr, load the wait counter with ROM_LATENCY-1, then go to WAIT.
REQ-017 WAIT: decrement the counter; at 0, go to RESP.
REQ-018 RESP: capture rom_dout, pulse ack[winner], present valid_moves, then go to IDLE.
REQ-019 Latency: a req sampled in IDLE at edge T gets ack at edge T+3+ROM_LATENCY-1.
REQ-020 Throughput: one transaction per 3+ROM_LATENCY cycles.
REQ-021 Nibble with base b = 4*x[4:0]: {row[b+3], row[b+2], row[b+0], row[b+1]}.
REQ-022 If x[4:0] > 18, the base exceeds row width; valid_moves is 4'b0000 and ack still pulses.
REQ-023 x bit 5 is ignored.
REQ-024 map_num, x and y are sampled only at grant; later changes do not affect the in-flight transaction.
REQ-025 A requester drops req in the cycle after ack. A req still high on returning to IDLE is a new request.
REQ-026 ack is zero outside RESP; valid_moves holds its last value outside RESP.
REQ-027 rom_addr holds its last value until the next READ.

Reset
REQ-028 On rst: state IDLE, ack 0, valid_moves 0, rom_addr 0, busy 0, counter 0, round-robin pointer 0.
REQ-029 Reset during READ, WAIT or RESP aborts the transaction with no ack; that agent is served after release if its req is still high.
REQ-030 The first arbitration after release uses pointer 0, so agent 0 has top priority.

Configuration
REQ-031 Macro COLLISION_ARB_ROUND_ROBIN_EN.
REQ-032 Macro defined: round-robin. Search starts at agent (last winner+1) mod 5, wrapping 4->0; the pointer updates at grant.
REQ-033 Macro undefined: fixed priority, bit0 highest, bit4 lowest; no pointer register.

Verification
REQ-034 Single request: req=5'b00001, map_num=2, y0=7, x0=3, ROM_LATENCY=1. Required: rom_addr=7'b1000111; ack=5'b00001 three edges after sampling; valid_moves = {row[15], row[14], row[12], row[13]}.
REQ-035 All five requests held continuously, round-robin build. Required: ack order 0,1,2,3,4,0; exactly one ack bit per RESP. Fixed-priority build: agent 0 only.
REQ-036 Out-of-range x: x=19, row all ones. Required: valid_moves=4'b0000 with ack pulse.
REQ-037 Sample-at-grant: change y and map_num in the cycle after grant. Required: rom_addr carries the original values.
REQ-038 Reset in WAIT with ROM_LATENCY=3. Required: no ack, all outputs zero; after release the held req is acked 5 cycles after sampling.
